uart_loader: RTL
================

// Module: uart_loader
// PURPOSE
//  Program/data loader downstream of uart_rx: consumes received bytes, parses a
//  32-bit little-endian word-count header, packs following bytes into 32-bit LE
//  words and writes them sequentially into instruction/data BRAM. Runs before the
//  core is released from boot; done/err gate core start.
// PARAMETERS
//  ADDR_W     14     word-address width of target memory (capacity 2**ADDR_W words)
//  BASE_ADDR  0      first word address written
// PORTS
//  clk        in   1       system clock
//  rstn       in   1       async active-low reset
//  rx_data    in   8       byte from uart_rx (valid only with rx_ready)
//  rx_ready   in   1       one-cycle pulse: rx_data valid
//  rx_ferr    in   1       framing error flag from uart_rx, sampled with rx_ready
//  start      in   1       arm loader; ignored while busy
//  wr_en      out  1       one-cycle memory write strobe
//  wr_addr    out  ADDR_W  word address for wr_en
//  wr_data    out  32      word for wr_en
//  busy       out  1       high in LEN/DATA(/CSUM)
//  done       out  1       sticky: load completed OK
//  err        out  1       sticky: load aborted
//  words_left out  32      remaining words of current load
// BEHAVIOUR
//  Reset (async, rstn=0): state IDLE; all outputs 0; byte counter, word counter 0.
//  States: IDLE, LEN, DATA, CSUM (macro only), DONE, ERR.
//  IDLE: rx bytes ignored. start=1 -> LEN, byte_cnt=0, clear done/err.
//  LEN: 4 bytes, first byte = bits[7:0]. On 4th byte: len>2**ADDR_W -> ERR;
//   len==0 -> DONE (or CSUM if enabled); else words_left=len, addr=BASE_ADDR -> DATA.
//  DATA: bytes packed LE; on 4th byte's rx_ready, next cycle wr_en=1 with wr_addr,
//   wr_data; then addr+=1 (mod 2**ADDR_W), words_left-=1. Transition on the write
//   that makes words_left 0 -> DONE (or CSUM).
//  Latency: rx_ready of final byte of word -> wr_en exactly 1 cycle.
//  Any rx_ready with rx_ferr=1 in LEN/DATA/CSUM -> ERR, no write of partial word.
//  DONE/ERR: done or err held high; rx bytes ignored; start=1 -> LEN (rearm).
//  start while busy: ignored. start coinciding with rx_ready in IDLE: byte ignored.
//  Reset mid-load: immediate abort, partial word discarded, all flags cleared.
//  busy, done, err mutually exclusive at all times.
// CONFIGURATION
//  UART_LOADER_CSUM_EN defined: after last word (or len==0) state CSUM awaits one
//   byte; it must equal 8-bit sum (mod 256) of all header and payload bytes;
//   match -> DONE, mismatch -> ERR. Sum resets on entry to LEN.
//  Not defined: no CSUM state, no sum register; DONE directly after last write.
// STRUCTURE
//  Package uart_loader_pkg: state enum loader_state_t, WORD_BYTES=4, LEN_BYTES=4.
//  Sub-module uart_byte_packer: 2-bit byte counter + 32-bit LE shift register,
//   outputs word and word_valid pulse; clear input used by FSM on state entry.
// TESTING
//  1 start; header 02 00 00 00; bytes 11 22 33 44 AA BB CC DD -> wr 0:44332211,
//    1:DDCCBBAA, each 1 cycle after 4th byte; done=1, busy=0.
//  2 header 00 00 00 00 -> no wr_en, done=1 (CSUM_EN: needs byte 00 first).
//  3 ADDR_W=4, header 11 00 00 00 (17>16) -> err=1, no writes.
//  4 rx_ferr=1 on 2nd byte of word 1 -> err=1, only word 0 written.
//  5 rstn low after 6 of 8 payload bytes -> all outputs 0; restart, full load OK.
//  6 CSUM_EN: header 01 00 00 00, 01 02 03 04, csum 0B -> done; csum 0C -> err.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot loader.
// The CSUM state exists only when UART_LOADER_CSUM_EN is defined.
package uart_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
`ifdef UART_LOADER_CSUM_EN
        ST_CSUM,
`endif
        ST_DONE,
        ST_ERR
    } loader_state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned LEN_BYTES  = 4;

endpackage

// File: rtl/uart_byte_packer.sv
// Packs a byte stream into 32-bit little-endian words; word/word_valid are
// combinational on the completing byte so the owner can register them.
module uart_byte_packer
    import uart_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt;
    logic [31:0] sreg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt  <= '0;
            sreg <= '0;
        end else if (clear) begin
            cnt  <= '0;
        end else if (byte_valid) begin
            sreg <= {byte_in, sreg[31:8]};
            cnt  <= cnt + 2'd1;
        end
    end

    // The first byte received ends up in bits [7:0] once four have shifted in.
    assign word       = {byte_in, sreg[31:8]};
    assign word_valid = byte_valid && !clear && (cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/uart_loader.sv
// Boot loader: length header then LE payload words written to BRAM.
// Define UART_LOADER_CSUM_EN to require a trailing 8-bit additive checksum byte.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              rx_ferr,
    input  logic              start,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       words_left
);

    localparam logic [32:0] CAPACITY = 33'd1 << ADDR_W;

    loader_state_t     state;
    logic [ADDR_W-1:0] addr;
    logic              active;
    logic              byte_ok;
    logic [31:0]       word;
    logic              word_valid;
`ifdef UART_LOADER_CSUM_EN
    logic [7:0]        sum;
`endif

    assign active  = (state == ST_LEN) || (state == ST_DATA);
    assign byte_ok = rx_ready && !rx_ferr && active;

    uart_byte_packer u_packer (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (!active),
        .byte_valid (byte_ok),
        .byte_in    (rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            addr       <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            words_left <= '0;
`ifdef UART_LOADER_CSUM_EN
            sum        <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
`ifdef UART_LOADER_CSUM_EN
            if (byte_ok)
                sum <= sum + rx_data;
`endif
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state <= ST_LEN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        err   <= 1'b0;
`ifdef UART_LOADER_CSUM_EN
                        sum   <= '0;
`endif
                    end
                end
                ST_LEN: begin
                    if (rx_ready && rx_ferr) begin
                        state <= ST_ERR;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else if (word_valid) begin
                        if ({1'b0, word} > CAPACITY) begin
                            state <= ST_ERR;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end else if (word == '0) begin
                            words_left <= '0;
`ifdef UART_LOADER_CSUM_EN
                            state <= ST_CSUM;
`else
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`endif
                        end else begin
                            words_left <= word;
                            addr       <= ADDR_W'(BASE_ADDR);
                            state      <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_ready && rx_ferr) begin
                        state <= ST_ERR;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else if (word_valid) begin
                        wr_en      <= 1'b1;
                        wr_addr    <= addr;
                        wr_data    <= word;
                        addr       <= addr + 1'b1;
                        words_left <= words_left - 32'd1;
                        if (words_left == 32'd1) begin
`ifdef UART_LOADER_CSUM_EN
                            state <= ST_CSUM;
`else
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef UART_LOADER_CSUM_EN
                ST_CSUM: begin
                    if (rx_ready) begin
                        busy <= 1'b0;
                        if (!rx_ferr && rx_data == sum) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
